// File: rtl/conveng_ctrl_pkg.sv
// Shared types and helpers for the convolution-engine frame sequencer.
package conveng_ctrl_pkg;

    // Width of the engine mode code (pattern_* values live in the engine params).
    localparam int modeWidth = 3;

    // Watchdog counter width; wide enough for the largest stall timeout.
    localparam int WDOG_W = 32;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RST,
        ST_RUN,
        ST_DONE,
        ST_ABORT
    } state_e;

    // Expected engine output pixels per frame.
    function automatic logic [31:0] frame_size(input int w, input int h);
        return 32'(w * h);
    endfunction

endpackage

// File: rtl/conveng_frame_ctrl_if.sv
// Handshake / data bundle between the frame sequencer, upstream and the engine.
interface conveng_frame_ctrl_if;
    import conveng_ctrl_pkg::*;

    logic                 newFrame;
    logic [modeWidth-1:0] iMode;
    logic                 iValid;
    logic                 iEngValid;
    logic                 iEngDone;
    logic                 oEngReset;
    logic                 oEngValid;
    logic [modeWidth-1:0] oEngMode;
    logic                 oBusy;
    logic                 oFrameDone;
    logic                 oError;
    logic                 oTimeout;
    logic [15:0]          oFrameCnt;
    logic [31:0]          oPixelCnt;

    // Sequencer side.
    modport slave (
        input  newFrame, iMode, iValid, iEngValid, iEngDone,
        output oEngReset, oEngValid, oEngMode, oBusy, oFrameDone,
               oError, oTimeout, oFrameCnt, oPixelCnt
    );

    // Stimulus / system side.
    modport master (
        output newFrame, iMode, iValid, iEngValid, iEngDone,
        input  oEngReset, oEngValid, oEngMode, oBusy, oFrameDone,
               oError, oTimeout, oFrameCnt, oPixelCnt
    );

endinterface

// File: rtl/conveng_watchdog.sv
// Clear/increment counter with a terminal-count flag. The terminal value is
// an input so one instance serves both the reset hold and the stall timeout.
module conveng_watchdog
    import conveng_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              inc_i,
    input  logic [WDOG_W-1:0] term_i,
    output logic              tc_o
);

    logic [WDOG_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)    cnt_d = '0;
        else if (inc_i) cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/conveng_frame_ctrl.sv
// Per-frame sequencer for the convolution engine: engine reset hold, mode
// latch, pixel-valid gating, output pixel count, completion/error/timeout.
// Optional: CONVENG_AUTO_RESTART_EN makes DONE restart the next frame directly.
module conveng_frame_ctrl
    import conveng_ctrl_pkg::*;
#(
    parameter int width         = 1920,
    parameter int height        = 1080,
    parameter int resetCycles   = 16,
    parameter int timeoutCycles = 4194304
) (
    input  logic                 clk,
    input  logic                 reset,
    conveng_frame_ctrl_if.slave  bus
);

    localparam logic [31:0]       FRAME   = frame_size(width, height);
    localparam logic [WDOG_W-1:0] RST_TC  = WDOG_W'(resetCycles - 1);
    localparam logic [WDOG_W-1:0] STALL_TC = WDOG_W'(timeoutCycles - 1);

    state_e               state_q, state_d;
    logic                 pend_q, pend_d;
    logic                 recov_q, recov_d;
    logic [modeWidth-1:0] mode_q, mode_d;
    logic [31:0]          pix_q, pix_d;
    logic [15:0]          fcnt_q, fcnt_d;
    logic                 erst_q, evld_q, evld_d, busy_q;
    logic                 done_q, err_q, err_d, tmo_q;
    logic                 wd_clr, wd_inc, wd_tc;
    logic [WDOG_W-1:0]    wd_term;

    // Shared counter: reset hold in INIT/RST, stall watchdog in RUN.
    assign wd_term = (state_q == ST_RUN) ? STALL_TC : RST_TC;

    conveng_watchdog u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear_i (wd_clr),
        .inc_i   (wd_inc),
        .term_i  (wd_term),
        .tc_o    (wd_tc)
    );

    // Next state, counters and registered-output values.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        recov_d = recov_q;
        mode_d  = mode_q;
        pix_d   = pix_q;
        fcnt_d  = fcnt_q;
        evld_d  = 1'b0;
        err_d   = 1'b0;
        wd_clr  = 1'b0;
        wd_inc  = 1'b0;

        // One-deep request queue while busy; ABORT discards requests.
        if (bus.newFrame && state_q != ST_IDLE && state_q != ST_ABORT)
            pend_d = 1'b1;

        case (state_q)
            ST_INIT: begin
                if (wd_tc) begin
                    state_d = ST_IDLE;
                    wd_clr  = 1'b1;
                end else begin
                    wd_inc  = 1'b1;
                end
            end
            ST_IDLE: begin
                wd_clr = 1'b1;
                if (bus.newFrame || pend_q) begin
                    state_d = ST_RST;
                    mode_d  = bus.iMode;
                    pix_d   = '0;
                    pend_d  = 1'b0;
                    recov_d = 1'b0;
                end
            end
            ST_RST: begin
                if (wd_tc) begin
                    // Recovery after an abort only flushes the engine.
                    state_d = recov_q ? ST_IDLE : ST_RUN;
                    recov_d = 1'b0;
                    wd_clr  = 1'b1;
                end else begin
                    wd_inc  = 1'b1;
                end
            end
            ST_RUN: begin
                evld_d = bus.iValid;
                if (bus.iEngValid) pix_d = pix_q + 1'b1;
                if (bus.iEngDone) begin
                    state_d = ST_DONE;
                    fcnt_d  = fcnt_q + 1'b1;
                    err_d   = (pix_d != FRAME);
                    wd_clr  = 1'b1;
                end else if (bus.iEngValid) begin
                    wd_clr  = 1'b1;
                end else if (wd_tc) begin
                    state_d = ST_ABORT;
                    wd_clr  = 1'b1;
                end else begin
                    wd_inc  = 1'b1;
                end
            end
            ST_DONE: begin
                wd_clr = 1'b1;
`ifdef CONVENG_AUTO_RESTART_EN
                state_d = ST_RST;
                mode_d  = bus.iMode;
                pix_d   = '0;
                recov_d = 1'b0;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_ABORT: begin
                wd_clr  = 1'b1;
                state_d = ST_RST;
                recov_d = 1'b1;
                pend_d  = 1'b0;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State and registered outputs; level outputs follow the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            pend_q  <= 1'b0;
            recov_q <= 1'b0;
            mode_q  <= '0;
            pix_q   <= '0;
            fcnt_q  <= '0;
            erst_q  <= 1'b1;
            evld_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            recov_q <= recov_d;
            mode_q  <= mode_d;
            pix_q   <= pix_d;
            fcnt_q  <= fcnt_d;
            erst_q  <= (state_d == ST_INIT) || (state_d == ST_RST);
            evld_q  <= evld_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            err_q   <= err_d;
            tmo_q   <= (state_d == ST_ABORT);
        end
    end

    assign bus.oEngReset  = erst_q;
    assign bus.oEngValid  = evld_q;
    assign bus.oEngMode   = mode_q;
    assign bus.oBusy      = busy_q;
    assign bus.oFrameDone = done_q;
    assign bus.oError     = err_q;
    assign bus.oTimeout   = tmo_q;
    assign bus.oFrameCnt  = fcnt_q;
    assign bus.oPixelCnt  = pix_q;

endmodule

// File: tb/tb_conveng_frame_ctrl.sv
// Directed bench for conveng_frame_ctrl: 8x4 frame, 4-cycle reset hold,
// 20-cycle stall timeout, default build (auto-restart disabled).
module tb_conveng_frame_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    conveng_frame_ctrl_if bus ();

    conveng_frame_ctrl #(
        .width         (8),
        .height        (4),
        .resetCycles   (4),
        .timeoutCycles (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_erst"},  32'(bus.oEngReset),  1);
        chk({p, "_evld"},  32'(bus.oEngValid),  0);
        chk({p, "_mode"},  32'(bus.oEngMode),   0);
        chk({p, "_busy"},  32'(bus.oBusy),      1);
        chk({p, "_done"},  32'(bus.oFrameDone), 0);
        chk({p, "_err"},   32'(bus.oError),     0);
        chk({p, "_tmo"},   32'(bus.oTimeout),   0);
        chk({p, "_fcnt"},  32'(bus.oFrameCnt),  0);
        chk({p, "_pcnt"},  bus.oPixelCnt,       0);
    endtask

    // From IDLE: request a frame, then walk through the 4-cycle engine reset.
    task automatic start_frame(input logic [2:0] mode);
        logic [2:0] other;
        other = ~mode;
        bus.newFrame = 1'b1;
        bus.iMode    = mode;
        step();
        bus.newFrame = 1'b0;
        bus.iMode    = other;
        chk("sf_busy", 32'(bus.oBusy),     1);
        chk("sf_erst", 32'(bus.oEngReset), 1);
        chk("sf_mode", 32'(bus.oEngMode),  32'(mode));
        step();
        chk("sf_vld_in_rst", 32'(bus.oEngValid), 0);
        step();
        step();
        chk("sf_erst_hold", 32'(bus.oEngReset), 1);
        step();
        chk("sf_erst_drop", 32'(bus.oEngReset), 0);
        chk("sf_mode_hold", 32'(bus.oEngMode),  32'(mode));
    endtask

    task automatic feed(input int n);
        bus.iEngValid = 1'b1;
        repeat (n) step();
        bus.iEngValid = 1'b0;
    endtask

    task automatic finish_frame(input logic coinc);
        bus.iEngDone  = 1'b1;
        bus.iEngValid = coinc;
        step();
        bus.iEngDone  = 1'b0;
        bus.iEngValid = 1'b0;
    endtask

    initial begin
        bus.newFrame  = 1'b0;
        bus.iMode     = '0;
        bus.iValid    = 1'b0;
        bus.iEngValid = 1'b0;
        bus.iEngDone  = 1'b0;

        // Reset state.
        step();
        step();
        chk_reset_vals("rst");

        // Release: engine reset held exactly 4 cycles.
        reset = 1'b1;
        chk("init_0", 32'(bus.oEngReset), 1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("init_hold", 32'(bus.oEngReset), 1);
        end
        step();
        chk("init_end_erst", 32'(bus.oEngReset), 0);
        chk("init_end_busy", 32'(bus.oBusy),     0);
        chk("init_end_fcnt", 32'(bus.oFrameCnt), 0);

        // Frame 1: exact pixel count, mode 3, upstream valids gated through.
        bus.iValid = 1'b1;
        start_frame(3'd3);
        feed(32);
        chk("f1_evld", 32'(bus.oEngValid), 1);
        chk("f1_pcnt_run", bus.oPixelCnt, 32);
        bus.iValid = 1'b0;
        finish_frame(1'b0);
        chk("f1_done", 32'(bus.oFrameDone), 1);
        chk("f1_err",  32'(bus.oError),     0);
        chk("f1_fcnt", 32'(bus.oFrameCnt),  1);
        chk("f1_pcnt", bus.oPixelCnt,       32);
        chk("f1_mode", 32'(bus.oEngMode),   3);
        step();
        chk("f1_done_off", 32'(bus.oFrameDone), 0);
        chk("f1_idle",     32'(bus.oBusy),      0);
        chk("f1_evld_off", 32'(bus.oEngValid),  0);

        // Frame 2: one pixel short -> error with done.
        start_frame(3'd5);
        feed(31);
        finish_frame(1'b0);
        chk("f2_done", 32'(bus.oFrameDone), 1);
        chk("f2_err",  32'(bus.oError),     1);
        chk("f2_pcnt", bus.oPixelCnt,       31);
        chk("f2_fcnt", 32'(bus.oFrameCnt),  2);
        step();
        chk("f2_err_off", 32'(bus.oError), 0);

        // Frame 3: last pixel coincident with done counts.
        start_frame(3'd6);
        feed(31);
        finish_frame(1'b1);
        chk("f3_done", 32'(bus.oFrameDone), 1);
        chk("f3_err",  32'(bus.oError),     0);
        chk("f3_pcnt", bus.oPixelCnt,       32);
        chk("f3_fcnt", 32'(bus.oFrameCnt),  3);
        step();

        // Stall: 20 RUN cycles with no engine valid -> abort and recovery.
        start_frame(3'd2);
        repeat (19) step();
        chk("to_early", 32'(bus.oTimeout), 0);
        step();
        chk("to_pulse", 32'(bus.oTimeout),   1);
        chk("to_fcnt",  32'(bus.oFrameCnt),  3);
        chk("to_nodone", 32'(bus.oFrameDone), 0);
        bus.newFrame = 1'b1;
        step();
        bus.newFrame = 1'b0;
        chk("to_pulse_off", 32'(bus.oTimeout),  0);
        chk("to_rec_erst",  32'(bus.oEngReset), 1);
        repeat (3) step();
        chk("to_rec_hold", 32'(bus.oEngReset), 1);
        step();
        chk("to_rec_end",  32'(bus.oEngReset), 0);
        chk("to_rec_idle", 32'(bus.oBusy),     0);
        step();
        chk("to_abort_req_dropped", 32'(bus.oBusy), 0);
        chk("to_fcnt_after", 32'(bus.oFrameCnt), 3);

        // Two requests during RUN -> exactly one extra frame.
        start_frame(3'd1);
        bus.newFrame = 1'b1;
        step();
        bus.newFrame = 1'b0;
        step();
        bus.newFrame = 1'b1;
        step();
        bus.newFrame = 1'b0;
        feed(32);
        finish_frame(1'b0);
        chk("pd_fcnt4", 32'(bus.oFrameCnt), 4);
        step();
        chk("pd_idle", 32'(bus.oBusy), 0);
        step();
        chk("pd_rst_busy", 32'(bus.oBusy),     1);
        chk("pd_rst_erst", 32'(bus.oEngReset), 1);
        chk("pd_mode",     32'(bus.oEngMode),  6);
        repeat (4) step();
        chk("pd_run", 32'(bus.oEngReset), 0);
        feed(32);
        finish_frame(1'b0);
        chk("pd_fcnt5", 32'(bus.oFrameCnt), 5);
        chk("pd_err",   32'(bus.oError),    0);
        step();
        step();
        chk("pd_only_one", 32'(bus.oBusy), 0);

        // Reset asserted mid-RUN at pixel 10.
        start_frame(3'd4);
        feed(10);
        chk("mr_pcnt", bus.oPixelCnt, 10);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("mr");
        bus.iEngDone = 1'b1;
        step();
        step();
        chk("mr_nodone", 32'(bus.oFrameDone), 0);
        chk("mr_notmo",  32'(bus.oTimeout),   0);
        bus.iEngDone = 1'b0;
        reset = 1'b1;
        repeat (4) step();
        chk("mr_reinit_erst", 32'(bus.oEngReset), 0);
        chk("mr_reinit_idle", 32'(bus.oBusy),     0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
